distributor: RTL and testbench
==============================

Name: distributor

Overview:
- 1-to-N counterpart of the N-to-1 interconnect. Accepts packets on one valid/ready input and steers each to one of CONNECT_NUM valid/ready outputs.
- Output selection comes from a destination field inside the packet.
- Each output has a one-entry buffer, so a stalled consumer does not block packets already buffered for other outputs.
- Used on the return path, e.g. master to slaves or processing elements.

Parameters:
- DATA_WIDTH, PACKET_WIDTH (from the shared include), width of a packet.
- CONNECT_NUM, 3, number of output ports; must be at least 2.
- DEST_LSB, 0, bit position of the destination field's LSB in the packet.
- DEST_WIDTH, 2, width of the destination field; 2**DEST_WIDTH must be at least CONNECT_NUM.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; asynchronous, active-high.
- RECEIVE_VALID  in  1  input packet valid.
- RECEIVE_READY  out  1  input can accept.
- RECEIVE_DATA  in  DATA_WIDTH  input packet.
- SEND_VALID  out  CONNECT_NUM  per-output valid.
- SEND_READY  in  CONNECT_NUM  per-output ready.
- SEND_DATA  out  DATA_WIDTH*CONNECT_NUM  flattened outputs; port i occupies bits [DATA_WIDTH*(i+1)-1 -: DATA_WIDTH].
- DROP_COUNT  out  16  number of packets dropped for an out-of-range destination; saturating.

Behaviour:
- Reset:
  - in_valid = 0, all slot_valid = 0, DROP_COUNT = 0, SEND_DATA = 0.
  - RECEIVE_READY = 1 while RST is low.
  - RECEIVE_READY = 0 while RST is high.
- Handshake rules:
  - A transfer occurs on an edge where VALID and READY are both 1.
  - Once SEND_VALID[i] is asserted, it stays asserted with stable data until SEND_READY[i].
- Input stage: holding register (in_valid, in_data).
  - dest = in_data[DEST_LSB +: DEST_WIDTH].
  - bad = (dest >= CONNECT_NUM).
  - in_move = in_valid & (bad | ~slot_valid[dest]).
  - RECEIVE_READY = ~in_valid | in_move. It is a function of registered state only, with no combinational path from SEND_READY or RECEIVE_DATA.
- Edge update, input register:
  - If RECEIVE_VALID & RECEIVE_READY: load in_data and set in_valid.
  - Else if in_move: clear in_valid.
- Edge update, slot i:
  - If in_move & ~bad & dest==i: load slot i and set slot_valid[i].
  - Else if SEND_VALID[i] & SEND_READY[i]: clear slot_valid[i].
  - A slot never loads and drains on the same edge, because in_move requires the slot to be empty beforehand.
- Bad destination: the packet is discarded on the in_move edge and DROP_COUNT increments, saturating at 16'hFFFF.
- SEND_VALID[i] = slot_valid[i]. SEND_DATA slice i = slot register i.
- Latency: a packet accepted on edge k appears on SEND_VALID[dest] after edge k+1.
- Throughput:
  - One packet per cycle when consecutive packets target different, empty outputs.
  - Back-to-back packets to the same output sustain at most 1 per 2 cycles, since the slot must drain before the next load.
- Ordering:
  - Packets to the same destination leave in arrival order.
  - Packets to different destinations may complete out of order.
- Head-of-line: a held packet whose slot is full stalls the input. Other slots keep draining.
- Reset mid-operation: all buffered packets are lost immediately and outputs deassert asynchronously.

Decomposition:
- Shared include (param.vh): DEST_LSB and DEST_WIDTH defaults as packet-format constants, next to PACKET_WIDTH.
- Sub-module distributor_slot:
  - One-entry register holding valid and data.
  - Ports: CLK, RST, LOAD, LOAD_DATA, SEND_VALID, SEND_READY, SEND_DATA.
  - Instantiated CONNECT_NUM times in a generate loop.
- Top level holds the input register, destination decode and drop counter.

Test Plan:
- Reset: RST=1 for 1 cycle -> SEND_VALID=3'b000, DROP_COUNT=0, RECEIVE_READY=0. After release, RECEIVE_READY=1.
- Single route: send packet with dest=2, data 'hA5...02, all SEND_READY=1 -> SEND_VALID=3'b100 exactly one edge after acceptance, and slice 2 equals the packet.
- Independent drain: SEND_READY=3'b000, send dest 0,1,2 back-to-back -> all three accepted in consecutive cycles and SEND_VALID=3'b111. Raise SEND_READY[1] only -> only port 1 drains; ports 0 and 2 hold their data.
- Stall: SEND_READY[0]=0, send two packets to dest 0 -> second held, RECEIVE_READY=0. Raise SEND_READY[0] -> both delivered in order with nothing lost.
- Drop: send dest=3 with CONNECT_NUM=3 -> no SEND_VALID, DROP_COUNT=1. A following dest=1 packet is delivered normally.
- Reset mid-flight: assert RST with SEND_VALID=3'b101 -> SEND_VALID goes to 0 asynchronously before the next edge. Random traffic afterwards (1000 packets with random SEND_READY, checked against per-port scoreboards) shows no loss or reordering.

Source files
------------

// File: rtl/distributor_pkg.sv
// distributor_pkg
//   Packet-format constants shared by the distributor, its output slot and
//   its bus interface: packet width, where the destination field sits in a
//   packet, and the width of the drop counter.
package distributor_pkg;

  localparam int PACKET_WIDTH       = 32;
  localparam int PKT_DEST_LSB       = 0;
  localparam int PKT_DEST_WIDTH     = 2;
  localparam int DEFAULT_CONNECT_NUM = 3;
  localparam int DROP_WIDTH         = 16;

endpackage

// File: rtl/distributor_if.sv
// distributor_if
//   Bundles the distributor's input valid/ready channel, its CONNECT_NUM
//   output valid/ready channels and the drop counter.
//   master : traffic source / sink side (drives RECEIVE_*, SEND_READY)
//   slave  : distributor side (drives RECEIVE_READY, SEND_VALID/DATA, DROP_COUNT)
//   SEND_DATA is flattened; port i occupies [DATA_WIDTH*(i+1)-1 -: DATA_WIDTH].
interface distributor_if
  import distributor_pkg::*;
#(
  parameter int DATA_WIDTH  = PACKET_WIDTH,
  parameter int CONNECT_NUM = DEFAULT_CONNECT_NUM
);

  logic                              RECEIVE_VALID;
  logic                              RECEIVE_READY;
  logic [DATA_WIDTH-1:0]             RECEIVE_DATA;
  logic [CONNECT_NUM-1:0]            SEND_VALID;
  logic [CONNECT_NUM-1:0]            SEND_READY;
  logic [DATA_WIDTH*CONNECT_NUM-1:0] SEND_DATA;
  logic [DROP_WIDTH-1:0]             DROP_COUNT;

  modport master (
    output RECEIVE_VALID, RECEIVE_DATA, SEND_READY,
    input  RECEIVE_READY, SEND_VALID, SEND_DATA, DROP_COUNT
  );

  modport slave (
    input  RECEIVE_VALID, RECEIVE_DATA, SEND_READY,
    output RECEIVE_READY, SEND_VALID, SEND_DATA, DROP_COUNT
  );

endinterface

// File: rtl/distributor_slot.sv
// distributor_slot
//   One-entry output buffer for a single distributor port.
//   CLK, RST   : clock, async active-high reset
//   LOAD       : capture LOAD_DATA and mark the slot full
//   LOAD_DATA  : packet to store
//   SEND_VALID : slot holds a packet
//   SEND_READY : consumer accepts the held packet this edge
//   SEND_DATA  : held packet, stable while SEND_VALID is high
module distributor_slot
  import distributor_pkg::*;
#(
  parameter int DATA_WIDTH = PACKET_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  LOAD,
  input  logic [DATA_WIDTH-1:0] LOAD_DATA,
  output logic                  SEND_VALID,
  input  logic                  SEND_READY,
  output logic [DATA_WIDTH-1:0] SEND_DATA
);

  logic                  slot_valid;
  logic [DATA_WIDTH-1:0] slot_data;

  // LOAD is only ever raised for an empty slot, so load and drain never
  // collide on the same edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      slot_valid <= 1'b0;
      slot_data  <= '0;
    end else if (LOAD) begin
      slot_valid <= 1'b1;
      slot_data  <= LOAD_DATA;
    end else if (slot_valid && SEND_READY) begin
      slot_valid <= 1'b0;
    end
  end

  assign SEND_VALID = slot_valid;
  assign SEND_DATA  = slot_data;

endmodule

// File: rtl/distributor.sv
// distributor
//   Steers packets from one valid/ready input to one of CONNECT_NUM
//   valid/ready outputs, chosen by the destination field inside the packet.
//   Each output owns a one-entry slot so a stalled consumer only blocks
//   packets headed for that same output. Packets whose destination is out
//   of range are discarded and counted in a saturating DROP_COUNT.
//   CLK : clock
//   RST : async active-high reset
//   bus : distributor_if.slave (RECEIVE_*, SEND_*, DROP_COUNT)
module distributor
  import distributor_pkg::*;
#(
  parameter int DATA_WIDTH  = PACKET_WIDTH,
  parameter int CONNECT_NUM = DEFAULT_CONNECT_NUM,
  parameter int DEST_LSB    = PKT_DEST_LSB,
  parameter int DEST_WIDTH  = PKT_DEST_WIDTH
) (
  input logic        CLK,
  input logic        RST,
  distributor_if.slave bus
);

  logic                              in_valid;
  logic [DATA_WIDTH-1:0]             in_data;
  logic [DEST_WIDTH-1:0]             dest;
  logic                              bad;
  logic                              slot_busy;
  logic                              in_move;
  logic                              rx_ready;
  logic [CONNECT_NUM-1:0]            slot_valid;
  logic [CONNECT_NUM-1:0]            load;
  logic [DATA_WIDTH-1:0]             slot_data [CONNECT_NUM];
  logic [DATA_WIDTH*CONNECT_NUM-1:0] send_flat;
  logic [DROP_WIDTH-1:0]             drop_count;

  assign dest = in_data[DEST_LSB +: DEST_WIDTH];
  // One extra bit so CONNECT_NUM == 2**DEST_WIDTH still compares correctly.
  assign bad  = ({1'b0, dest} >= (DEST_WIDTH + 1)'(CONNECT_NUM));

  always_comb begin
    slot_busy = 1'b0;
    for (int i = 0; i < CONNECT_NUM; i++) begin
      if (dest == DEST_WIDTH'(i)) slot_busy = slot_valid[i];
    end
  end

  // Held packet leaves the input register either into its (empty) slot or
  // into the bin when the destination is out of range.
  assign in_move = in_valid && (bad || !slot_busy);

  // Depends only on registered state (and reset), never on SEND_READY or
  // RECEIVE_DATA.
  assign rx_ready = !RST && (!in_valid || in_move);

  always_comb begin
    load = '0;
    for (int i = 0; i < CONNECT_NUM; i++) begin
      load[i] = in_move && !bad && (dest == DEST_WIDTH'(i));
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      in_valid <= 1'b0;
      in_data  <= '0;
    end else if (bus.RECEIVE_VALID && rx_ready) begin
      in_valid <= 1'b1;
      in_data  <= bus.RECEIVE_DATA;
    end else if (in_move) begin
      in_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      drop_count <= '0;
    end else if (in_move && bad && (drop_count != {DROP_WIDTH{1'b1}})) begin
      drop_count <= drop_count + 1'b1;
    end
  end

  for (genvar g = 0; g < CONNECT_NUM; g++) begin : g_slot
    distributor_slot #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_slot (
      .CLK        (CLK),
      .RST        (RST),
      .LOAD       (load[g]),
      .LOAD_DATA  (in_data),
      .SEND_VALID (slot_valid[g]),
      .SEND_READY (bus.SEND_READY[g]),
      .SEND_DATA  (slot_data[g])
    );
  end

  always_comb begin
    send_flat = '0;
    for (int i = 0; i < CONNECT_NUM; i++) begin
      send_flat[DATA_WIDTH*i +: DATA_WIDTH] = slot_data[i];
    end
  end

  assign bus.RECEIVE_READY = rx_ready;
  assign bus.SEND_VALID    = slot_valid;
  assign bus.SEND_DATA     = send_flat;
  assign bus.DROP_COUNT    = drop_count;

endmodule

// File: tb/tb_distributor.sv
// tb_distributor
//   Directed checks of the distributor with CONNECT_NUM=3, 2-bit destination
//   at bit 0, followed by random traffic checked against per-port queues.
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge (or 1 time unit after it).
module tb_distributor;
  import distributor_pkg::*;

  localparam int DW = 32;
  localparam int CN = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;

  distributor_if #(.DATA_WIDTH(DW), .CONNECT_NUM(CN)) bus ();

  distributor #(
    .DATA_WIDTH  (DW),
    .CONNECT_NUM (CN),
    .DEST_LSB    (0),
    .DEST_WIDTH  (2)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] port_data(input int i);
    return bus.SEND_DATA[DW*i +: DW];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.RECEIVE_VALID = 1'b0;
    bus.RECEIVE_DATA  = '0;
    bus.SEND_READY    = '0;
    @(negedge clk);
    n_total++; if (bus.SEND_VALID !== 3'b000) begin n_bad++; $display("FAIL reset_send_valid: got %b want 000", bus.SEND_VALID); end
    n_total++; if (bus.DROP_COUNT !== 16'd0) begin n_bad++; $display("FAIL reset_drop_count: got %0d want 0", bus.DROP_COUNT); end
    n_total++; if (bus.RECEIVE_READY !== 1'b0) begin n_bad++; $display("FAIL reset_ready_in_reset: got %b want 0", bus.RECEIVE_READY); end
    n_total++; if (bus.SEND_DATA !== '0) begin n_bad++; $display("FAIL reset_send_data: got %h want 0", bus.SEND_DATA); end
    rst = 1'b0;
    #1;
    n_total++; if (bus.RECEIVE_READY !== 1'b1) begin n_bad++; $display("FAIL reset_ready_after: got %b want 1", bus.RECEIVE_READY); end
  endtask

  task automatic test_single_route();
    bus.SEND_READY = 3'b111;
    @(negedge clk);
    bus.RECEIVE_VALID = 1'b1;
    bus.RECEIVE_DATA  = 32'hA5A5_A502;
    #1;
    n_total++; if (bus.RECEIVE_READY !== 1'b1) begin n_bad++; $display("FAIL route_ready: got %b want 1", bus.RECEIVE_READY); end
    @(negedge clk);
    bus.RECEIVE_VALID = 1'b0;
    n_total++; if (bus.SEND_VALID !== 3'b000) begin n_bad++; $display("FAIL route_early: got %b want 000", bus.SEND_VALID); end
    @(negedge clk);
    n_total++; if (bus.SEND_VALID !== 3'b100) begin n_bad++; $display("FAIL route_valid: got %b want 100", bus.SEND_VALID); end
    n_total++; if (port_data(2) !== 32'hA5A5_A502) begin n_bad++; $display("FAIL route_data: got %h want a5a5a502", port_data(2)); end
    @(negedge clk);
    n_total++; if (bus.SEND_VALID !== 3'b000) begin n_bad++; $display("FAIL route_drain: got %b want 000", bus.SEND_VALID); end
  endtask

  task automatic test_independent_drain();
    logic [DW-1:0] pkt [3];
    pkt[0] = 32'h1111_1100;
    pkt[1] = 32'h2222_2201;
    pkt[2] = 32'h3333_3302;
    bus.SEND_READY = 3'b000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.RECEIVE_VALID = 1'b1;
      bus.RECEIVE_DATA  = pkt[i];
      #1;
      n_total++; if (bus.RECEIVE_READY !== 1'b1) begin n_bad++; $display("FAIL drain_accept_%0d: got %b want 1", i, bus.RECEIVE_READY); end
    end
    @(negedge clk);
    bus.RECEIVE_VALID = 1'b0;
    @(negedge clk);
    n_total++; if (bus.SEND_VALID !== 3'b111) begin n_bad++; $display("FAIL drain_all_valid: got %b want 111", bus.SEND_VALID); end
    for (int i = 0; i < 3; i++) begin
      n_total++; if (port_data(i) !== pkt[i]) begin n_bad++; $display("FAIL drain_data_%0d: got %h want %h", i, port_data(i), pkt[i]); end
    end
    bus.SEND_READY = 3'b010;
    @(negedge clk);
    bus.SEND_READY = 3'b000;
    for (int c = 0; c < 2; c++) begin
      n_total++; if (bus.SEND_VALID !== 3'b101) begin n_bad++; $display("FAIL drain_only_port1_%0d: got %b want 101", c, bus.SEND_VALID); end
      n_total++; if (port_data(0) !== pkt[0]) begin n_bad++; $display("FAIL drain_hold0_%0d: got %h want %h", c, port_data(0), pkt[0]); end
      n_total++; if (port_data(2) !== pkt[2]) begin n_bad++; $display("FAIL drain_hold2_%0d: got %h want %h", c, port_data(2), pkt[2]); end
      @(negedge clk);
    end
    bus.SEND_READY = 3'b101;
    @(negedge clk);
    bus.SEND_READY = 3'b000;
    n_total++; if (bus.SEND_VALID !== 3'b000) begin n_bad++; $display("FAIL drain_empty: got %b want 000", bus.SEND_VALID); end
  endtask

  task automatic test_stall();
    bus.SEND_READY = 3'b000;
    @(negedge clk);
    bus.RECEIVE_VALID = 1'b1;
    bus.RECEIVE_DATA  = 32'h1234_5600;
    @(negedge clk);
    bus.RECEIVE_DATA  = 32'h6543_2100;
    #1;
    n_total++; if (bus.RECEIVE_READY !== 1'b1) begin n_bad++; $display("FAIL stall_second_accept: got %b want 1", bus.RECEIVE_READY); end
    @(negedge clk);
    bus.RECEIVE_VALID = 1'b0;
    #1;
    n_total++; if (bus.RECEIVE_READY !== 1'b0) begin n_bad++; $display("FAIL stall_ready_low: got %b want 0", bus.RECEIVE_READY); end
    n_total++; if (bus.SEND_VALID !== 3'b001) begin n_bad++; $display("FAIL stall_valid: got %b want 001", bus.SEND_VALID); end
    n_total++; if (port_data(0) !== 32'h1234_5600) begin n_bad++; $display("FAIL stall_first_data: got %h want 12345600", port_data(0)); end
    @(negedge clk);
    n_total++; if (bus.RECEIVE_READY !== 1'b0) begin n_bad++; $display("FAIL stall_ready_held: got %b want 0", bus.RECEIVE_READY); end
    bus.SEND_READY = 3'b001;
    @(negedge clk);
    n_total++; if (bus.SEND_VALID[0] !== 1'b0) begin n_bad++; $display("FAIL stall_gap: got %b want 0", bus.SEND_VALID[0]); end
    n_total++; if (bus.RECEIVE_READY !== 1'b1) begin n_bad++; $display("FAIL stall_release: got %b want 1", bus.RECEIVE_READY); end
    @(negedge clk);
    n_total++; if (bus.SEND_VALID !== 3'b001) begin n_bad++; $display("FAIL stall_second_valid: got %b want 001", bus.SEND_VALID); end
    n_total++; if (port_data(0) !== 32'h6543_2100) begin n_bad++; $display("FAIL stall_second_data: got %h want 65432100", port_data(0)); end
    @(negedge clk);
    n_total++; if (bus.SEND_VALID !== 3'b000) begin n_bad++; $display("FAIL stall_done: got %b want 000", bus.SEND_VALID); end
  endtask

  task automatic test_drop();
    bus.SEND_READY = 3'b111;
    @(negedge clk);
    bus.RECEIVE_VALID = 1'b1;
    bus.RECEIVE_DATA  = 32'hDEAD_0003;
    @(negedge clk);
    bus.RECEIVE_VALID = 1'b0;
    n_total++; if (bus.DROP_COUNT !== 16'd0) begin n_bad++; $display("FAIL drop_early: got %0d want 0", bus.DROP_COUNT); end
    @(negedge clk);
    n_total++; if (bus.SEND_VALID !== 3'b000) begin n_bad++; $display("FAIL drop_no_valid: got %b want 000", bus.SEND_VALID); end
    n_total++; if (bus.DROP_COUNT !== 16'd1) begin n_bad++; $display("FAIL drop_count: got %0d want 1", bus.DROP_COUNT); end
    n_total++; if (bus.RECEIVE_READY !== 1'b1) begin n_bad++; $display("FAIL drop_ready: got %b want 1", bus.RECEIVE_READY); end
    bus.RECEIVE_VALID = 1'b1;
    bus.RECEIVE_DATA  = 32'hBEEF_0001;
    @(negedge clk);
    bus.RECEIVE_VALID = 1'b0;
    @(negedge clk);
    n_total++; if (bus.SEND_VALID !== 3'b010) begin n_bad++; $display("FAIL drop_next_valid: got %b want 010", bus.SEND_VALID); end
    n_total++; if (port_data(1) !== 32'hBEEF_0001) begin n_bad++; $display("FAIL drop_next_data: got %h want beef0001", port_data(1)); end
    @(negedge clk);
    n_total++; if (bus.DROP_COUNT !== 16'd1) begin n_bad++; $display("FAIL drop_count_stable: got %0d want 1", bus.DROP_COUNT); end
  endtask

  task automatic test_reset_midflight();
    bus.SEND_READY = 3'b000;
    @(negedge clk);
    bus.RECEIVE_VALID = 1'b1;
    bus.RECEIVE_DATA  = 32'h0A0A_0A00;
    @(negedge clk);
    bus.RECEIVE_DATA  = 32'h0C0C_0C02;
    @(negedge clk);
    bus.RECEIVE_VALID = 1'b0;
    @(negedge clk);
    n_total++; if (bus.SEND_VALID !== 3'b101) begin n_bad++; $display("FAIL midrst_pre: got %b want 101", bus.SEND_VALID); end
    rst = 1'b1;
    #1;
    n_total++; if (bus.SEND_VALID !== 3'b000) begin n_bad++; $display("FAIL midrst_async_valid: got %b want 000", bus.SEND_VALID); end
    n_total++; if (bus.DROP_COUNT !== 16'd0) begin n_bad++; $display("FAIL midrst_drop: got %0d want 0", bus.DROP_COUNT); end
    n_total++; if (bus.RECEIVE_READY !== 1'b0) begin n_bad++; $display("FAIL midrst_ready: got %b want 0", bus.RECEIVE_READY); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++; if (bus.RECEIVE_READY !== 1'b1) begin n_bad++; $display("FAIL midrst_ready_after: got %b want 1", bus.RECEIVE_READY); end
  endtask

  task automatic test_random_traffic();
    logic [DW-1:0] q [CN][$];
    logic [DW-1:0] exp_data;
    logic [DW-1:0] data;
    int offered;
    int cycles;
    int exp_drop;
    int dest;
    int busy;
    logic taken;
    offered  = 0;
    cycles   = 0;
    exp_drop = 0;
    taken    = 1'b0;
    busy     = 1;
    bus.RECEIVE_VALID = 1'b0;
    while (busy != 0 && cycles < 30000) begin
      @(negedge clk);
      cycles++;
      if (taken) bus.RECEIVE_VALID = 1'b0;
      if (!bus.RECEIVE_VALID && offered < 1000 && $urandom_range(0, 3) != 0) begin
        dest = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
        data = $urandom();
        data[1:0] = 2'(dest);
        bus.RECEIVE_VALID = 1'b1;
        bus.RECEIVE_DATA  = data;
        offered++;
      end
      bus.SEND_READY = (offered >= 1000) ? 3'b111 : 3'($urandom_range(0, 7));
      #1;
      taken = bus.RECEIVE_VALID && bus.RECEIVE_READY;
      if (taken) begin
        if (bus.RECEIVE_DATA[1:0] == 2'd3) exp_drop++;
        else q[bus.RECEIVE_DATA[1:0]].push_back(bus.RECEIVE_DATA);
      end
      for (int i = 0; i < CN; i++) begin
        if (bus.SEND_VALID[i] && bus.SEND_READY[i]) begin
          n_total++;
          if (q[i].size() == 0) begin
            n_bad++;
            $display("FAIL rand_unexpected_port%0d: got %h want nothing", i, port_data(i));
          end else begin
            exp_data = q[i].pop_front();
            if (port_data(i) !== exp_data) begin
              n_bad++;
              $display("FAIL rand_order_port%0d: got %h want %h", i, port_data(i), exp_data);
            end
          end
        end
      end
      busy = 0;
      if (offered < 1000 || bus.RECEIVE_VALID) busy = 1;
      for (int i = 0; i < CN; i++) if (q[i].size() != 0) busy = 1;
    end
    bus.RECEIVE_VALID = 1'b0;
    n_total++; if (busy != 0) begin n_bad++; $display("FAIL rand_timeout: got %0d cycles want fewer than 30000", cycles); end
    repeat (3) @(negedge clk);
    n_total++; if (bus.DROP_COUNT !== 16'(exp_drop)) begin n_bad++; $display("FAIL rand_drop_count: got %0d want %0d", bus.DROP_COUNT, exp_drop); end
    n_total++; if (bus.SEND_VALID !== 3'b000) begin n_bad++; $display("FAIL rand_leftover: got %b want 000", bus.SEND_VALID); end
  endtask

  initial begin
    test_reset();
    test_single_route();
    test_independent_drain();
    test_stall();
    test_drop();
    test_reset_midflight();
    test_random_traffic();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
